hw_mem_pool: RTL and testbench
==============================

Name: hw_mem_pool

Overview:
- Free-cell address pool for one GSM ingress port; the responder end of the allocator's hmp request interface.
- Hands out free cell addresses on request, reclaims addresses that egress releases after a cell has been read out, and reports when enough cells are free for a maximum-length packet.
- One instance per port.
- Internally a circular free-list FIFO that initialises itself after reset or clear.

Parameters:
AWIDTH, 7, width of a cell address.
PWIDTH, 7, log2 of pool depth; POOL_SIZE = 2^PWIDTH; PWIDTH <= AWIDTH.
POOL_BASE, 0, first cell address owned by this pool; POOL_BASE + POOL_SIZE - 1 must fit in AWIDTH bits.
FREE_THRESH, 7, o_bf_free_flag is asserted when the free count is >= this value (one max-length packet).

Ports:
clk  in  1  single clock, 80 MHz domain.
rst_n  in  1  asynchronous active-low reset.
clr  in  1  synchronous clear; restarts initialisation.
i_hmp_rd  in  1  allocator request for one free address.
o_hmp_valid  out  1  response strobe; o_hmp_addr is valid.
o_hmp_addr  out  AWIDTH  allocated cell address.
i_free_en  in  1  egress releases one cell.
i_free_addr  in  AWIDTH  address being released.
o_bf_free_flag  out  1  free count >= FREE_THRESH.
o_free_cnt  out  PWIDTH+1  current number of free cells.
o_init_done  out  1  pool initialised and serving requests.
o_err  out  3  sticky flags: [0] underflow, [1] overflow, [2] bad free; cleared only by rst_n or clr.

Behaviour:
- Reset values: all outputs 0; rd_ptr = 0, wr_ptr = 0, count = 0; FSM in INIT with idx = 0.
- FSM states: INIT and RUN.

INIT:
- Writes address POOL_BASE + idx into RAM[idx], one entry per cycle, for idx = 0 .. POOL_SIZE-1.
- On the last write: count = POOL_SIZE, wr_ptr wraps to 0, state moves to RUN.
- o_init_done rises on the first RUN cycle.
- i_hmp_rd and i_free_en are ignored in INIT.
- An i_hmp_rd in INIT sets no error and produces no response.

RUN, request handling:
- i_hmp_rd with count > 0: pop RAM[rd_ptr] and increment rd_ptr (wraps modulo POOL_SIZE). Next cycle, o_hmp_valid = 1 for exactly one cycle with the popped address. Latency is fixed at 1 cycle.
- i_hmp_rd with count == 0: no pop; next cycle o_hmp_valid = 0; set o_err[0].
- Back-to-back requests are allowed every cycle.

RUN, free handling:
- i_free_en with address in [POOL_BASE, POOL_BASE+POOL_SIZE-1] and count < POOL_SIZE: write to RAM[wr_ptr], increment wr_ptr.
- Out-of-range address: dropped; set o_err[2].
- count == POOL_SIZE: dropped; set o_err[1].

Simultaneous events and count:
- i_hmp_rd and i_free_en in the same cycle: both take effect; count is unchanged.
- Exception: with count == 0, the read underflows; there is no bypass of the freed address. The free is still accepted, so count becomes 1.
- count updates in the same cycle as the push/pop; o_free_cnt and o_bf_free_flag are registered and reflect count one cycle after the event.

clr and reset:
- clr (any state): next cycle, state = INIT, idx = 0, pointers and count = 0, o_err = 0, o_hmp_valid = 0, o_init_done = 0.
- A pending response is cancelled; outstanding allocations are forgotten.
- rst_n low mid-operation: the same effect asynchronously.

Implementation notes:
- RAM is inferred as a POOL_SIZE x AWIDTH simple dual-port memory with a registered read.

Optional Feature:
- Macro HM_DOUBLE_FREE_CHK_EN.
- When defined:
  - A POOL_SIZE-bit allocated bitmap is kept.
  - The bit is set on a successful pop and cleared on an accepted free.
  - A free whose bit is already 0 (double free, or free of a never-allocated cell) is dropped and sets o_err[2].
  - The bitmap is cleared in INIT.
- When undefined:
  - No bitmap.
  - Any in-range free with count < POOL_SIZE is accepted blindly.

Test Plan:
Use PWIDTH=4, POOL_BASE=16, AWIDTH=7, FREE_THRESH=7 for all scenarios.
1. Release rst_n -> o_init_done rises after 16 cycles, o_free_cnt=16, o_bf_free_flag=1; 3 consecutive rd -> o_hmp_valid on cycles +1,+2,+3 with addresses 16,17,18.
2. From init, 16 rd -> addresses 16..31, o_free_cnt=0, o_bf_free_flag=0; a 17th rd -> o_hmp_valid stays 0, o_err=3'b001.
3. Pool empty; free 20, then 25; then 2 rd -> returns 20 then 25 (FIFO order); o_free_cnt 0->1->2->1->0.
4. Pool full (16); free 17 -> dropped, o_err[1]=1, o_free_cnt=16; free 40 -> o_err[2]=1; same-cycle rd+free at count 9 -> count stays 9, one valid response.
5. Pop 10 cells, assert clr for 1 cycle -> o_init_done=0, o_err=0, reinit 16 cycles, first rd returns 16.
6. With HM_DOUBLE_FREE_CHK_EN: pop 16, free 16, free 16 again -> second free dropped, o_err[2]=1, o_free_cnt=1. Without the macro: both frees accepted, o_free_cnt=2.

Source files
------------

// File: rtl/hw_mem_pool.sv
// Free-cell address pool for one GSM ingress port: circular free-list FIFO that self-initialises.
// Optional allocated-bitmap double-free check enabled by defining HM_DOUBLE_FREE_CHK_EN.
module hw_mem_pool #(
   parameter int AWIDTH      = 7,
   parameter int PWIDTH      = 7,
   parameter int POOL_BASE   = 0,
   parameter int FREE_THRESH = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              i_hmp_rd,
   output logic              o_hmp_valid,
   output logic [AWIDTH-1:0] o_hmp_addr,
   input  logic              i_free_en,
   input  logic [AWIDTH-1:0] i_free_addr,
   output logic              o_bf_free_flag,
   output logic [PWIDTH:0]   o_free_cnt,
   output logic              o_init_done,
   output logic [2:0]        o_err
);
   localparam int                POOL_SIZE = 1 << PWIDTH;
   localparam logic [AWIDTH-1:0] BASE_A    = AWIDTH'(POOL_BASE);
   localparam logic [PWIDTH:0]   FULL_CNT  = (PWIDTH+1)'(POOL_SIZE);
   localparam logic [PWIDTH:0]   THRESH    = (PWIDTH+1)'(FREE_THRESH);

   typedef enum logic {ST_INIT, ST_RUN} state_t;
   state_t r_state, w_state_nxt;

   logic [AWIDTH-1:0] r_ram [POOL_SIZE];
   logic [PWIDTH-1:0] r_idx, r_rd_ptr, r_wr_ptr;
   logic [PWIDTH:0]   r_count, r_free_cnt;
   logic              r_bf, r_hmp_valid;
   logic [AWIDTH-1:0] r_hmp_addr;
   logic [2:0]        r_err;

   logic              w_run, w_rd_req, w_empty, w_full, w_pop, w_free_req;
   logic              w_in_range, w_alloc_ok, w_push, w_init_last;
   logic [AWIDTH:0]   w_off;
   logic              w_we;
   logic [PWIDTH-1:0] w_waddr;
   logic [AWIDTH-1:0] w_wdata;

   assign w_run       = (r_state == ST_RUN);
   assign w_rd_req    = w_run & i_hmp_rd & ~clr;
   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == FULL_CNT);
   assign w_pop       = w_rd_req & ~w_empty;
   assign w_free_req  = w_run & i_free_en & ~clr;
   // Borrow bit and high bits of the offset both land above PWIDTH when out of range
   assign w_off       = {1'b0, i_free_addr} - {1'b0, BASE_A};
   assign w_in_range  = ((w_off >> PWIDTH) == '0);
   assign w_push      = w_free_req & w_in_range & ~w_full & w_alloc_ok;
   assign w_init_last = (r_state == ST_INIT) & (r_idx == '1);

`ifdef HM_DOUBLE_FREE_CHK_EN
   logic [POOL_SIZE-1:0] r_alloc;
   logic [PWIDTH-1:0]    w_fidx;
   logic [AWIDTH-1:0]    w_ret_off;

   assign w_fidx     = w_off[PWIDTH-1:0];
   assign w_ret_off  = r_hmp_addr - BASE_A;
   assign w_alloc_ok = r_alloc[w_fidx];

   // Popped address is only known once the registered read returns, so mark it then
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alloc <= '0;
      end else if (clr || r_state == ST_INIT) begin
         r_alloc <= '0;
      end else begin
         if (r_hmp_valid) r_alloc[w_ret_off[PWIDTH-1:0]] <= 1'b1;
         if (w_push)      r_alloc[w_fidx] <= 1'b0;
      end
   end
`else
   assign w_alloc_ok = 1'b1;
`endif

   always_comb begin
      w_state_nxt = r_state;
      if (clr)              w_state_nxt = ST_INIT;
      else if (w_init_last) w_state_nxt = ST_RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_INIT;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_wr_ptr;
      w_wdata = i_free_addr;
      if (r_state == ST_INIT) begin
         w_we    = 1'b1;
         w_waddr = r_idx;
         w_wdata = BASE_A + AWIDTH'(r_idx);
      end else if (w_push) begin
         w_we    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) r_ram[w_waddr] <= w_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx       <= '0;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_free_cnt  <= '0;
         r_bf        <= 1'b0;
         r_hmp_valid <= 1'b0;
         r_hmp_addr  <= '0;
         r_err       <= '0;
      end else if (clr) begin
         r_idx       <= '0;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_free_cnt  <= '0;
         r_bf        <= 1'b0;
         r_hmp_valid <= 1'b0;
         r_hmp_addr  <= '0;
         r_err       <= '0;
      end else begin
         r_hmp_valid <= w_pop;
         if (w_pop) begin
            r_hmp_addr <= r_ram[r_rd_ptr];
            r_rd_ptr   <= r_rd_ptr + PWIDTH'(1);
         end
         if (w_push) r_wr_ptr <= r_wr_ptr + PWIDTH'(1);
         if (r_state == ST_INIT) begin
            r_idx <= r_idx + PWIDTH'(1);
            if (w_init_last) r_count <= FULL_CNT;
         end else begin
            r_count <= r_count + (PWIDTH+1)'(w_push) - (PWIDTH+1)'(w_pop);
         end
         r_err <= r_err | {w_free_req & (~w_in_range | (~w_full & ~w_alloc_ok)),
                           w_free_req & w_in_range & w_full,
                           w_rd_req & w_empty};
         r_free_cnt <= r_count;
         r_bf       <= (r_count >= THRESH);
      end
   end

   assign o_hmp_valid    = r_hmp_valid;
   assign o_hmp_addr     = r_hmp_addr;
   assign o_free_cnt     = r_free_cnt;
   assign o_bf_free_flag = r_bf;
   assign o_init_done    = w_run;
   assign o_err          = r_err;
endmodule

// File: tb/tb_hw_mem_pool.sv
// Directed self-checking bench for hw_mem_pool (PWIDTH=4, POOL_BASE=16, AWIDTH=7, FREE_THRESH=7).
// Expectations for the last scenario follow HM_DOUBLE_FREE_CHK_EN when defined.
module tb_hw_mem_pool;
   logic       clk = 1'b0;
   logic       rst_n, clr, i_hmp_rd, i_free_en;
   logic [6:0] i_free_addr;
   logic       o_hmp_valid, o_bf_free_flag, o_init_done;
   logic [6:0] o_hmp_addr;
   logic [4:0] o_free_cnt;
   logic [2:0] o_err;
   int         n_pass = 0;
   int         n_total = 0;

   hw_mem_pool #(.AWIDTH(7), .PWIDTH(4), .POOL_BASE(16), .FREE_THRESH(7)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .i_hmp_rd(i_hmp_rd),
      .o_hmp_valid(o_hmp_valid), .o_hmp_addr(o_hmp_addr),
      .i_free_en(i_free_en), .i_free_addr(i_free_addr),
      .o_bf_free_flag(o_bf_free_flag), .o_free_cnt(o_free_cnt),
      .o_init_done(o_init_done), .o_err(o_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_init();
      bit done;
      rst_n = 1'b0; clr = 1'b0; i_hmp_rd = 1'b0; i_free_en = 1'b0; i_free_addr = '0;
      tick();
      rst_n = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         tick();
         done = o_init_done;
      end
      n_total++;
      if (!done) $display("FAIL init_timeout: o_init_done=%b, required 1", o_init_done);
      else n_pass++;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; i_hmp_rd = 1'b0; i_free_en = 1'b0; i_free_addr = '0;
      tick();
      n_total++;
      if ({o_hmp_valid, o_hmp_addr, o_bf_free_flag, o_free_cnt, o_init_done, o_err} !== '0)
         $display("FAIL reset_outputs: valid=%b addr=%0d bf=%b cnt=%0d done=%b err=%b, required all 0",
                  o_hmp_valid, o_hmp_addr, o_bf_free_flag, o_free_cnt, o_init_done, o_err);
      else n_pass++;
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      n_total++;
      if (o_init_done !== 1'b0) $display("FAIL init_early: done=%b after 15 cycles, required 0", o_init_done);
      else n_pass++;
      tick();
      n_total++;
      if (o_init_done !== 1'b1) $display("FAIL init_16: done=%b after 16 cycles, required 1", o_init_done);
      else n_pass++;
      tick();
      n_total++;
      if (o_free_cnt !== 5'd16 || o_bf_free_flag !== 1'b1)
         $display("FAIL init_cnt: cnt=%0d bf=%b, required 16/1", o_free_cnt, o_bf_free_flag);
      else n_pass++;
      i_hmp_rd = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++;
         if (o_hmp_valid !== 1'b1 || o_hmp_addr !== 7'(16 + i))
            $display("FAIL rd3_%0d: valid=%b addr=%0d, required 1/%0d", i, o_hmp_valid, o_hmp_addr, 16 + i);
         else n_pass++;
      end
      i_hmp_rd = 1'b0;
      tick();
      tick();
      n_total++;
      if (o_hmp_valid !== 1'b0 || o_free_cnt !== 5'd13)
         $display("FAIL rd3_after: valid=%b cnt=%0d, required 0/13", o_hmp_valid, o_free_cnt);
      else n_pass++;
   endtask

   task automatic test_init_ignore();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; i_hmp_rd = 1'b1; i_free_en = 1'b1; i_free_addr = 7'd20;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_total++;
         if (o_hmp_valid !== 1'b0) $display("FAIL init_rd_%0d: valid=%b, required 0", i, o_hmp_valid);
         else n_pass++;
      end
      i_hmp_rd = 1'b0; i_free_en = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      n_total++;
      if (o_err !== 3'b000 || o_free_cnt !== 5'd16 || o_init_done !== 1'b1)
         $display("FAIL init_ignore: err=%b cnt=%0d done=%b, required 000/16/1", o_err, o_free_cnt, o_init_done);
      else n_pass++;
   endtask

   task automatic test_drain_and_refill();
      do_init();
      i_hmp_rd = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         n_total++;
         if (o_hmp_valid !== 1'b1 || o_hmp_addr !== 7'(16 + i))
            $display("FAIL drain_%0d: valid=%b addr=%0d, required 1/%0d", i, o_hmp_valid, o_hmp_addr, 16 + i);
         else n_pass++;
      end
      tick();
      i_hmp_rd = 1'b0;
      n_total++;
      if (o_hmp_valid !== 1'b0 || o_err !== 3'b001 || o_free_cnt !== 5'd0 || o_bf_free_flag !== 1'b0)
         $display("FAIL underflow: valid=%b err=%b cnt=%0d bf=%b, required 0/001/0/0",
                  o_hmp_valid, o_err, o_free_cnt, o_bf_free_flag);
      else n_pass++;
      i_free_en = 1'b1; i_free_addr = 7'd20;
      tick();
      i_free_addr = 7'd25;
      tick();
      n_total++;
      if (o_free_cnt !== 5'd1) $display("FAIL refill_cnt1: cnt=%0d, required 1", o_free_cnt);
      else n_pass++;
      i_free_en = 1'b0;
      tick();
      n_total++;
      if (o_free_cnt !== 5'd2) $display("FAIL refill_cnt2: cnt=%0d, required 2", o_free_cnt);
      else n_pass++;
      i_hmp_rd = 1'b1;
      tick();
      n_total++;
      if (o_hmp_valid !== 1'b1 || o_hmp_addr !== 7'd20)
         $display("FAIL fifo_first: valid=%b addr=%0d, required 1/20", o_hmp_valid, o_hmp_addr);
      else n_pass++;
      tick();
      n_total++;
      if (o_hmp_valid !== 1'b1 || o_hmp_addr !== 7'd25 || o_free_cnt !== 5'd1)
         $display("FAIL fifo_second: valid=%b addr=%0d cnt=%0d, required 1/25/1", o_hmp_valid, o_hmp_addr, o_free_cnt);
      else n_pass++;
      i_hmp_rd = 1'b0;
      tick();
      n_total++;
      if (o_hmp_valid !== 1'b0 || o_free_cnt !== 5'd0)
         $display("FAIL fifo_empty: valid=%b cnt=%0d, required 0/0", o_hmp_valid, o_free_cnt);
      else n_pass++;
   endtask

   task automatic test_free_errors();
      do_init();
      i_free_en = 1'b1; i_free_addr = 7'd17;
      tick();
      i_free_en = 1'b0;
      tick();
      n_total++;
      if (o_err !== 3'b010 || o_free_cnt !== 5'd16)
         $display("FAIL overflow: err=%b cnt=%0d, required 010/16", o_err, o_free_cnt);
      else n_pass++;
      i_free_en = 1'b1; i_free_addr = 7'd40;
      tick();
      i_free_en = 1'b0;
      n_total++;
      if (o_err !== 3'b110) $display("FAIL bad_free: err=%b, required 110", o_err);
      else n_pass++;
      i_hmp_rd = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      i_hmp_rd = 1'b0;
      tick();
      tick();
      n_total++;
      if (o_free_cnt !== 5'd9 || o_bf_free_flag !== 1'b1)
         $display("FAIL cnt9: cnt=%0d bf=%b, required 9/1", o_free_cnt, o_bf_free_flag);
      else n_pass++;
      i_hmp_rd = 1'b1; i_free_en = 1'b1; i_free_addr = 7'd16;
      tick();
      i_hmp_rd = 1'b0; i_free_en = 1'b0;
      n_total++;
      if (o_hmp_valid !== 1'b1 || o_hmp_addr !== 7'd23)
         $display("FAIL same_cycle_resp: valid=%b addr=%0d, required 1/23", o_hmp_valid, o_hmp_addr);
      else n_pass++;
      tick();
      n_total++;
      if (o_hmp_valid !== 1'b0 || o_free_cnt !== 5'd9 || o_err !== 3'b110)
         $display("FAIL same_cycle_cnt: valid=%b cnt=%0d err=%b, required 0/9/110", o_hmp_valid, o_free_cnt, o_err);
      else n_pass++;
   endtask

   task automatic test_clear();
      do_init();
      i_free_en = 1'b1; i_free_addr = 7'd5;
      tick();
      i_free_en = 1'b0;
      i_hmp_rd = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0; i_hmp_rd = 1'b0;
      n_total++;
      if (o_init_done !== 1'b0 || o_err !== 3'b000 || o_hmp_valid !== 1'b0)
         $display("FAIL clr_state: done=%b err=%b valid=%b, required 0/000/0", o_init_done, o_err, o_hmp_valid);
      else n_pass++;
      for (int i = 0; i < 15; i++) tick();
      n_total++;
      if (o_init_done !== 1'b0) $display("FAIL reinit_early: done=%b, required 0", o_init_done);
      else n_pass++;
      tick();
      n_total++;
      if (o_init_done !== 1'b1) $display("FAIL reinit_16: done=%b, required 1", o_init_done);
      else n_pass++;
      i_hmp_rd = 1'b1;
      tick();
      i_hmp_rd = 1'b0;
      n_total++;
      if (o_hmp_valid !== 1'b1 || o_hmp_addr !== 7'd16)
         $display("FAIL reinit_rd: valid=%b addr=%0d, required 1/16", o_hmp_valid, o_hmp_addr);
      else n_pass++;
   endtask

   task automatic test_double_free();
      logic [4:0] exp_cnt;
      logic [2:0] exp_err;
`ifdef HM_DOUBLE_FREE_CHK_EN
      exp_cnt = 5'd1; exp_err = 3'b100;
`else
      exp_cnt = 5'd2; exp_err = 3'b000;
`endif
      do_init();
      i_hmp_rd = 1'b1;
      for (int i = 0; i < 16; i++) tick();
      i_hmp_rd = 1'b0;
      tick();
      i_free_en = 1'b1; i_free_addr = 7'd16;
      tick();
      tick();
      i_free_en = 1'b0;
      tick();
      tick();
      n_total++;
      if (o_free_cnt !== exp_cnt || o_err !== exp_err)
         $display("FAIL double_free: cnt=%0d err=%b, required %0d/%b", o_free_cnt, o_err, exp_cnt, exp_err);
      else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; i_hmp_rd = 1'b0; i_free_en = 1'b0; i_free_addr = '0;
      test_reset();
      test_init_ignore();
      test_drain_and_refill();
      test_free_errors();
      test_clear();
      test_double_free();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
